instr_encoder_loader: RTL

- Inverse of the immediate-extend path: takes decoded fields (opcode, registers, funct, format, 32-bit signed immediate) and packs them into 32-bit RV32I instruction words.
- Streams the packed words into instruction memory through its write port at consecutive word addresses.
- Used to load test programs into the single-cycle core's instruction memory before release from hold.
- Checks each immediate for range and alignment against its format and rejects words that do not fit.

---
 rtl/instr_encoder_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded RV32I fields into instruction words and streams them into imem
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  Fmt,
  input  logic [6:0]  Op,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [2:0]  Funct3,
  input  logic [6:0]  Funct7,
  input  logic [31:0] Imm,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  output logic [6:0]  count,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] ptr_q, ptr_d;
  logic [6:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic [31:0] packed_word;
  logic [1:0]  chk_code;
  logic        xfer;

  assign xfer = in_valid & in_ready;

  // Pack fields per format and classify the immediate; range is tested before alignment
  always_comb begin
    packed_word = 32'h0;
    chk_code    = 2'b00;
    case (Fmt)
      3'b000: begin
        packed_word = {Imm[11:0], Rs1, Funct3, Rd, Op};
        if ($signed(Imm) < -32'sd2048 || $signed(Imm) > 32'sd2047) chk_code = 2'b01;
      end
      3'b001: begin
        packed_word = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Op};
        if ($signed(Imm) < -32'sd2048 || $signed(Imm) > 32'sd2047) chk_code = 2'b01;
      end
      3'b010: begin
        packed_word = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Op};
        if ($signed(Imm) < -32'sd4096 || $signed(Imm) > 32'sd4094) chk_code = 2'b01;
        else if (Imm[0])                                            chk_code = 2'b10;
      end
      3'b011: begin
        packed_word = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Op};
        if ($signed(Imm) < -32'sd1048576 || $signed(Imm) > 32'sd1048574) chk_code = 2'b01;
        else if (Imm[0])                                                  chk_code = 2'b10;
      end
      3'b100: begin
        packed_word = {Funct7, Rs2, Rs1, Funct3, Rd, Op};
      end
      default: begin
        chk_code = 2'b11;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start always reopens a session; a full session or a last bundle closes it
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (count_q == DEPTH_W)    state_d = S_DONE;
          else if (xfer && in_last)  state_d = S_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: accept bundles only while loading, not on a start cycle, and not once full
  always_comb begin
    in_ready = (state_q == S_LOAD) && !start && (count_q != DEPTH_W) && !reset;
    done     = (state_q == S_DONE);
  end

  // Datapath next state: accepted words advance pointer/count, rejected ones only flag the error
  always_comb begin
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;
    if (start) begin
      ptr_d   = BASE_ADDR;
      count_d = 7'd0;
      err_d   = 1'b0;
      code_d  = 2'b00;
    end else if (xfer) begin
      if (chk_code == 2'b00) begin
        we_d    = 1'b1;
        wa_d    = ptr_q;
        wd_d    = packed_word;
        ptr_d   = ptr_q + 32'd4;
        count_d = count_q + 7'd1;
      end else begin
        err_d = 1'b1;
        if (code_q == 2'b00) code_d = chk_code;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      wa_q    <= BASE_ADDR;
      wd_q    <= 32'h0;
      ptr_q   <= BASE_ADDR;
      count_q <= 7'd0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // A write still pending in the output register is suppressed while reset is held
  assign WE       = we_q & ~reset;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign count    = count_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule
